// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_pkg : default 320x240 raster constants and ce_divider decode   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

  localparam int   c_h_active = 320;
  localparam int   c_h_fp     = 8;
  localparam int   c_h_sync   = 32;
  localparam int   c_h_bp     = 40;
  localparam int   c_v_active = 240;
  localparam int   c_v_fp     = 3;
  localparam int   c_v_sync   = 3;
  localparam int   c_v_bp     = 16;
  localparam int   c_hcnt_w   = 9;
  localparam int   c_vcnt_w   = 9;
  localparam logic c_sync_pol = 1'b0;

  // Select 0 means divide by 4; any other select n means divide by n+1.
  function automatic logic [3:0] ce_div_decode(input logic [2:0] sel);
    logic [3:0] n;
    n = (sel == 3'd0) ? 4'd4 : ({1'b0, sel} + 4'd1);
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pix_ce_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pix_ce_gen : pixel clock-enable divider with wrap-synchronous N reload      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pix_ce_gen
  import video_timing_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] ce_divider,
  output logic       ce_pix
);

  logic [3:0] r_div_cnt;
  logic [3:0] r_div_n;
  logic       r_fresh;
  logic       r_ce;
  logic [3:0] w_n;
  logic       w_wrap;

  // Until the first edge after reset, the live select defines the period.
  always_comb begin
    w_n    = r_fresh ? ce_div_decode(ce_divider) : r_div_n;
    w_wrap = enable && (r_div_cnt == (w_n - 4'd1));
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= 4'd0;
      r_div_n   <= 4'd4;
      r_fresh   <= 1'b1;
      r_ce      <= 1'b0;
    end else begin
      if (!enable) begin
        r_div_cnt <= 4'd0;
        r_ce      <= 1'b0;
      end else if (w_wrap) begin
        r_div_cnt <= 4'd0;
        r_ce      <= 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 4'd1;
        r_ce      <= 1'b0;
      end
      if (r_fresh || w_wrap) begin
        r_div_n <= ce_div_decode(ce_divider);
      end
      r_fresh <= 1'b0;
    end
  end

  assign ce_pix = r_ce & enable;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_timing_gen : raster counters, blanking/sync strobes and pixel enable  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = c_h_active,
  parameter int   H_FP       = c_h_fp,
  parameter int   H_SYNC     = c_h_sync,
  parameter int   H_BP       = c_h_bp,
  parameter int   V_ACTIVE   = c_v_active,
  parameter int   V_FP       = c_v_fp,
  parameter int   V_SYNC     = c_v_sync,
  parameter int   V_BP       = c_v_bp,
  parameter int   HCNT_WIDTH = c_hcnt_w,
  parameter int   VCNT_WIDTH = c_vcnt_w,
  parameter logic SYNC_POL   = c_sync_pol
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [2:0]            ce_divider,
  output logic                  ce_pix,
  output logic [HCNT_WIDTH-1:0] hcount,
  output logic [VCNT_WIDTH-1:0] vcount,
  output logic                  HBlank,
  output logic                  VBlank,
  output logic                  HSync,
  output logic                  VSync,
  output logic                  line_start,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL - 1) >= (1 << HCNT_WIDTH)) begin : g_hcnt_too_narrow
      $fatal(1, "HCNT_WIDTH cannot hold H_TOTAL-1");
    end
    if ((V_TOTAL - 1) >= (1 << VCNT_WIDTH)) begin : g_vcnt_too_narrow
      $fatal(1, "VCNT_WIDTH cannot hold V_TOTAL-1");
    end
  endgenerate

  localparam logic [HCNT_WIDTH-1:0] c_h_last   = HCNT_WIDTH'(H_TOTAL - 1);
  localparam logic [HCNT_WIDTH-1:0] c_hb_start = HCNT_WIDTH'(H_ACTIVE);
  localparam logic [HCNT_WIDTH-1:0] c_hs_start = HCNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [HCNT_WIDTH:0]   c_hs_end   = (HCNT_WIDTH + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_WIDTH-1:0] c_v_last   = VCNT_WIDTH'(V_TOTAL - 1);
  localparam logic [VCNT_WIDTH-1:0] c_vb_start = VCNT_WIDTH'(V_ACTIVE);
  localparam logic [VCNT_WIDTH-1:0] c_vs_start = VCNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [VCNT_WIDTH:0]   c_vs_end   = (VCNT_WIDTH + 1)'(V_ACTIVE + V_FP + V_SYNC);

  logic                  w_ce;
  logic [HCNT_WIDTH-1:0] r_hcount;
  logic [VCNT_WIDTH-1:0] r_vcount;
  logic                  r_hblank;
  logic                  r_vblank;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_line_start;
  logic                  r_frame_start;
  logic [HCNT_WIDTH-1:0] w_h_next;
  logic [VCNT_WIDTH-1:0] w_v_next;
  logic                  w_hs_on;
  logic                  w_vs_on;

  pix_ce_gen u_pix_ce_gen (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .enable     (enable),
    .ce_divider (ce_divider),
    .ce_pix     (w_ce)
  );

  // Strobes decode the next counter values so they land with the counters.
  always_comb begin
    w_h_next = (r_hcount == c_h_last) ? '0 : (r_hcount + 1'b1);
    w_v_next = r_vcount;
    if (r_hcount == c_h_last) begin
      w_v_next = (r_vcount == c_v_last) ? '0 : (r_vcount + 1'b1);
    end
    w_hs_on = (w_h_next >= c_hs_start) && ({1'b0, w_h_next} < c_hs_end);
    w_vs_on = (w_v_next >= c_vs_start) && ({1'b0, w_v_next} < c_vs_end);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hblank      <= 1'b0;
      r_vblank      <= 1'b0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (w_ce) begin
        r_hcount      <= w_h_next;
        r_vcount      <= w_v_next;
        r_hblank      <= (w_h_next >= c_hb_start);
        r_vblank      <= (w_v_next >= c_vb_start);
        r_hsync       <= w_hs_on ? SYNC_POL : ~SYNC_POL;
        r_vsync       <= w_vs_on ? SYNC_POL : ~SYNC_POL;
        r_line_start  <= (w_h_next == '0);
        r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
      end
    end
  end

  assign ce_pix      = w_ce;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign HBlank      = r_hblank;
  assign VBlank      = r_vblank;
  assign HSync       = r_hsync;
  assign VSync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_timing_gen : directed bench for the default and a small raster     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_video_timing_gen;

  typedef struct {
    int cyc;
    bit sel;
    int h;
    int v;
    bit hb, vb, hs, vs, ls, fs, ce;
  } vec_t;

  localparam int NV = 30;

  logic       clk;
  logic       rst_m, rst_a, en_m, en_a;
  logic [2:0] cd_m, cd_a;
  logic       m_ce, m_hb, m_vb, m_hs, m_vs, m_ls, m_fs;
  logic       a_ce, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs;
  logic [8:0] m_h, m_v, a_h, a_v;

  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc     = 0;
  bit   mon     = 0;
  int   mon_bad = 0;
  int   m_fs_cnt = 0;
  bit   prev_avs = 0;
  int   fs_cyc[$];
  vec_t tbl [NV];

  video_timing_gen u_main (
    .clk_sys(clk), .reset_n(rst_m), .enable(en_m), .ce_divider(cd_m),
    .ce_pix(m_ce), .hcount(m_h), .vcount(m_v), .HBlank(m_hb), .VBlank(m_vb),
    .HSync(m_hs), .VSync(m_vs), .line_start(m_ls), .frame_start(m_fs)
  );

  video_timing_gen #(
    .H_ACTIVE(256), .V_ACTIVE(20), .V_BP(4), .SYNC_POL(1'b1), .HCNT_WIDTH(9), .VCNT_WIDTH(9)
  ) u_alt (
    .clk_sys(clk), .reset_n(rst_a), .enable(en_a), .ce_divider(cd_a),
    .ce_pix(a_ce), .hcount(a_h), .vcount(a_v), .HBlank(a_hb), .VBlank(a_vb),
    .HSync(a_hs), .VSync(a_vs), .line_start(a_ls), .frame_start(a_fs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int h, input int v, input bit hb, input bit vb,
                                     input bit hs, input bit vs, input bit ls, input bit fs,
                                     input bit ce);
    return {16'(h), 16'(v), 1'b0, hb, vb, hs, vs, ls, fs, ce, 16'h0};
  endfunction

  // One clock; the small raster is checked every cycle while mon is set.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mon) begin
      if (a_hb !== (a_h >= 256)) mon_bad++;
      if (a_hs !== (a_h >= 264 && a_h < 296)) mon_bad++;
      if (a_vb !== (a_v >= 20)) mon_bad++;
      if (a_vs !== (a_v >= 23 && a_v <= 25)) mon_bad++;
      if (a_vs !== prev_avs && a_h != 0) mon_bad++;
      if (a_ls && a_h != 0) mon_bad++;
      prev_avs = a_vs;
      if (a_fs) begin
        fs_cyc.push_back(cyc);
        if (a_h != 0 || a_v != 0) mon_bad++;
      end
      if (m_fs) m_fs_cnt++;
    end
  endtask

  initial begin
    int exp_ce[11];
    int got_ce[$];
    int bad;
    int first;
    logic [63:0] obs;

    //              cyc    sel h    v   hb vb hs vs ls fs ce
    tbl[0]  = '{0,     0, 0,   0,  0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{0,     1, 0,   0,  0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{2,     1, 0,   0,  0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{3,     0, 0,   0,  0, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{3,     1, 1,   0,  0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{4,     0, 0,   0,  0, 0, 1, 1, 0, 0, 1};
    tbl[6]  = '{5,     0, 1,   0,  0, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{511,   1, 255, 0,  0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{513,   1, 256, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{529,   1, 264, 0,  1, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{591,   1, 295, 0,  1, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{593,   1, 296, 0,  1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1277,  0, 319, 0,  0, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{1281,  0, 320, 0,  1, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{1309,  0, 327, 0,  1, 0, 1, 1, 0, 0, 0};
    tbl[15] = '{1313,  0, 328, 0,  1, 0, 0, 1, 0, 0, 0};
    tbl[16] = '{1437,  0, 359, 0,  1, 0, 0, 1, 0, 0, 0};
    tbl[17] = '{1441,  0, 360, 0,  1, 0, 1, 1, 0, 0, 0};
    tbl[18] = '{1601,  0, 0,   1,  0, 0, 1, 1, 1, 0, 0};
    tbl[19] = '{1602,  0, 0,   1,  0, 0, 1, 1, 0, 0, 0};
    tbl[20] = '{3201,  0, 0,   2,  0, 0, 1, 1, 1, 0, 0};
    tbl[21] = '{13439, 1, 335, 19, 1, 0, 0, 0, 0, 0, 0};
    tbl[22] = '{13441, 1, 0,   20, 0, 1, 0, 0, 1, 0, 0};
    tbl[23] = '{15455, 1, 335, 22, 1, 1, 0, 0, 0, 0, 0};
    tbl[24] = '{15457, 1, 0,   23, 0, 1, 0, 1, 1, 0, 0};
    tbl[25] = '{17471, 1, 335, 25, 1, 1, 0, 1, 0, 0, 0};
    tbl[26] = '{17473, 1, 0,   26, 0, 1, 0, 0, 1, 0, 0};
    tbl[27] = '{20161, 0, 240, 12, 0, 0, 1, 1, 0, 0, 0};
    tbl[28] = '{20161, 1, 0,   0,  0, 0, 0, 0, 1, 1, 0};
    tbl[29] = '{20162, 1, 0,   0,  0, 0, 0, 0, 0, 0, 1};

    rst_m = 1'b0; rst_a = 1'b0; en_m = 1'b1; en_a = 1'b1; cd_m = 3'd0; cd_a = 3'd1;
    #12;
    @(negedge clk);
    rst_m = 1'b1; rst_a = 1'b1;
    cyc = 0;
    mon = 1'b1;

    for (int i = 0; i < NV; i++) begin
      while (cyc < tbl[i].cyc) step();
      if (tbl[i].sel)
        obs = pk(a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs, a_ce);
      else
        obs = pk(m_h, m_v, m_hb, m_vb, m_hs, m_vs, m_ls, m_fs, m_ce);
      chk($sformatf("vec[%0d]", i), obs,
          pk(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].hs, tbl[i].vs,
             tbl[i].ls, tbl[i].fs, tbl[i].ce));
    end

    // Two full small-raster frames at N=2.
    while (cyc < 40400) step();
    mon = 1'b0;
    chk("alt_decode_monitor", 64'(mon_bad), 64'd0);
    chk("alt_frame_start_count", 64'(fs_cyc.size()), 64'd2);
    if (fs_cyc.size() == 2) begin
      chk("alt_frame_start_0", 64'(fs_cyc[0]), 64'd20161);
      chk("alt_frame_start_1", 64'(fs_cyc[1]), 64'd40321);
    end
    chk("main_no_frame_start", 64'(m_fs_cnt), 64'd0);

    // Divider change from /2 to /3 mid-period.
    rst_m = 1'b0; cd_m = 3'd1;
    @(negedge clk);
    rst_m = 1'b1;
    cyc = 0;
    exp_ce = '{2, 4, 6, 8, 11, 14, 17, 20, 23, 26, 29};
    for (int k = 1; k <= 30; k++) begin
      step();
      if (m_ce) got_ce.push_back(cyc);
      if (cyc == 6) cd_m = 3'd2;
    end
    chk("div_change_pulse_count", 64'(got_ce.size()), 64'd11);
    for (int k = 0; k < 11; k++) begin
      if (k < got_ce.size())
        chk($sformatf("div_change_pulse[%0d]", k), 64'(got_ce[k]), 64'(exp_ce[k]));
    end

    // Enable freeze at hcount=100 with N=4.
    rst_m = 1'b0; cd_m = 3'd0;
    @(negedge clk);
    rst_m = 1'b1;
    cyc = 0;
    while (cyc < 402) step();
    chk("freeze_entry_hcount", 64'(m_h), 64'd100);
    en_m = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (m_h != 100 || m_ce || m_ls) bad++;
    end
    chk("freeze_hold_cycles_bad", 64'(bad), 64'd0);
    en_m = 1'b1;
    first = -1;
    for (int k = 0; k < 8 && first < 0; k++) begin
      step();
      if (m_ce) first = cyc;
    end
    chk("reenable_first_ce_cycle", 64'(first), 64'd456);
    step();
    chk("reenable_hcount_advance", 64'(m_h), 64'd101);

    // Asynchronous reset of the small raster in the middle of a frame.
    for (int k = 0; k < 25000 && a_v != 15; k++) step();
    chk("alt_reach_v15", 64'(a_v), 64'd15);
    for (int k = 0; k < 101; k++) step();
    @(posedge clk);
    #3;
    rst_a = 1'b0;
    #1;
    chk("async_reset_outputs", pk(a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs, a_ce),
        pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_a = 1'b1;
    step();
    step();
    chk("post_reset_first_ce", pk(a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_ls, a_fs, a_ce),
        pk(0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
